// File: rtl/csa_resolver_if.sv
// Operand-pair / result handshake bundle for csa_resolver.
// slave is the resolver side, master is the producer/consumer side.
interface csa_resolver_if #(
  parameter int Width = 16
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [Width-1:0] in_sum_i;
  logic [Width-1:0] in_carry_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [Width-1:0] out_result_o;
  logic             out_carry_o;

  modport slave (
    input  in_valid_i, in_sum_i, in_carry_i, out_ready_i,
    output in_ready_o, out_valid_o, out_result_o, out_carry_o
  );

  modport master (
    output in_valid_i, in_sum_i, in_carry_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_result_o, out_carry_o
  );
endinterface

// File: rtl/csa_resolver.sv
// Chunk-serial adder closing a carry-save tree: result after Width/ChunkWidth cycles of ADD.
// Single pair in flight; result is held in HOLD until out_ready_i, new pairs only taken in IDLE.
module csa_resolver #(
  parameter int Width      = 16,
  parameter int ChunkWidth = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  csa_resolver_if.slave  bus
);
  localparam int NumChunks = Width / ChunkWidth;
  localparam int IdxW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;

  typedef enum logic [1:0] {IDLE, ADD, HOLD} state_e;

  state_e                state_q, state_d;
  logic [Width-1:0]      sum_q, sum_d;
  logic [Width-1:0]      cvec_q, cvec_d;
  logic [Width-1:0]      result_q, result_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  cin_q, cin_d;
  logic                  cout_q, cout_d;
  logic [ChunkWidth:0]   chunk_add;
  logic [Width-1:0]      chunk_ext;

  // Operands shift right one chunk per cycle so the adder always sees bit 0;
  // the result fills from the top, landing in place after NumChunks shifts.
  assign chunk_add = {1'b0, sum_q[ChunkWidth-1:0]}
                   + {1'b0, cvec_q[ChunkWidth-1:0]}
                   + {{ChunkWidth{1'b0}}, cin_q};
  assign chunk_ext = Width'(chunk_add[ChunkWidth-1:0]);

  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    cvec_d   = cvec_q;
    result_d = result_q;
    idx_d    = idx_q;
    cin_d    = cin_q;
    cout_d   = cout_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid_i) begin
          sum_d   = bus.in_sum_i;
          cvec_d  = bus.in_carry_i;
          idx_d   = '0;
          cin_d   = 1'b0;
          state_d = ADD;
        end
      end
      ADD: begin
        result_d = (result_q >> ChunkWidth) | (chunk_ext << (Width - ChunkWidth));
        sum_d    = sum_q >> ChunkWidth;
        cvec_d   = cvec_q >> ChunkWidth;
        cin_d    = chunk_add[ChunkWidth];
        idx_d    = idx_q + 1'b1;
        if (idx_q == IdxW'(NumChunks - 1)) begin
          cout_d  = chunk_add[ChunkWidth];
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      sum_q    <= '0;
      cvec_q   <= '0;
      result_q <= '0;
      idx_q    <= '0;
      cin_q    <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      cvec_q   <= cvec_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      cin_q    <= cin_d;
      cout_q   <= cout_d;
    end
  end

  assign bus.in_ready_o   = (state_q == IDLE);
  assign bus.out_valid_o  = (state_q == HOLD);
  assign bus.out_result_o = result_q;
  assign bus.out_carry_o  = cout_q;
endmodule

// File: tb/tb_csa_resolver.sv
// Bench for csa_resolver: vector table and corner sequences on the default build,
// plus a random sweep on ChunkWidth = 16 and ChunkWidth = 1 builds.
module tb_csa_resolver;
  localparam int W = 16;

  typedef struct {
    logic [W-1:0] s;
    logic [W-1:0] c;
    logic [W-1:0] r;
    logic         co;
  } vec_t;

  typedef struct {
    logic [W-1:0] r;
    logic         co;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  exp_t q16[$];
  exp_t q1[$];
  vec_t tbl[7];

  always #5 clk = ~clk;

  csa_resolver_if #(.Width(W)) bus0 ();
  csa_resolver_if #(.Width(W)) bus16 ();
  csa_resolver_if #(.Width(W)) bus1 ();

  csa_resolver #(.Width(W), .ChunkWidth(4))  dut    (.clk_i(clk), .rst_i(rst), .bus(bus0));
  csa_resolver #(.Width(W), .ChunkWidth(16)) dut_16 (.clk_i(clk), .rst_i(rst), .bus(bus16));
  csa_resolver #(.Width(W), .ChunkWidth(1))  dut_1  (.clk_i(clk), .rst_i(rst), .bus(bus1));

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmp_exp(input string name, input exp_t e, input logic [W-1:0] r, input logic co);
    check_eq({name, " result"}, 32'(r), 32'(e.r));
    check_eq({name, " carry"}, 32'(co), 32'(e.co));
  endtask

  // Call at a negedge while bus0 is IDLE; returns at the negedge after acceptance.
  task automatic send(input logic [W-1:0] s, input logic [W-1:0] c,
                      input logic [W-1:0] r, input logic co);
    exp_t e;
    check_eq("in_ready before send", 32'(bus0.in_ready_o), 32'd1);
    bus0.in_valid_i = 1'b1;
    bus0.in_sum_i   = s;
    bus0.in_carry_i = c;
    e.r = r;
    e.co = co;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus0.in_valid_i = 1'b0;
    bus0.in_sum_i   = 16'($urandom);
    bus0.in_carry_i = 16'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (bus0.out_valid_o !== 1'b1 && lat < 64) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic pop_compare(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: output with empty scoreboard, got %h", name, bus0.out_result_o);
    end else begin
      e = sb_q.pop_front();
      cmp_exp(name, e, bus0.out_result_o, bus0.out_carry_o);
    end
  endtask

  task automatic collect(input string name);
    int lat;
    wait_valid(lat);
    check_eq({name, " latency"}, 32'(lat), 32'd4);
    pop_compare(name);
    bus0.out_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus0.out_ready_i = 1'b0;
    check_eq({name, " in_ready after drain"}, 32'(bus0.in_ready_o), 32'd1);
    check_eq({name, " out_valid after drain"}, 32'(bus0.out_valid_o), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    bit d16, d1;
    logic [W-1:0] s, c;
    logic [W:0] full;
    exp_t e;

    tbl[0] = '{16'h1234, 16'h0001, 16'h1235, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b1};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1};
    tbl[3] = '{16'h8000, 16'h8000, 16'h0000, 1'b1};
    tbl[4] = '{16'h0000, 16'h0000, 16'h0000, 1'b0};
    tbl[5] = '{16'h0F0F, 16'h00F1, 16'h1000, 1'b0};
    tbl[6] = '{16'hAAAA, 16'h5555, 16'hFFFF, 1'b0};

    rst = 1'b1;
    bus0.in_valid_i = 1'b0;  bus0.in_sum_i = '0;  bus0.in_carry_i = '0;  bus0.out_ready_i = 1'b0;
    bus16.in_valid_i = 1'b0; bus16.in_sum_i = '0; bus16.in_carry_i = '0; bus16.out_ready_i = 1'b1;
    bus1.in_valid_i = 1'b0;  bus1.in_sum_i = '0;  bus1.in_carry_i = '0;  bus1.out_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("reset in_ready", 32'(bus0.in_ready_o), 32'd1);
    check_eq("reset out_valid", 32'(bus0.out_valid_o), 32'd0);
    check_eq("reset result", 32'(bus0.out_result_o), 32'h0);
    check_eq("reset carry", 32'(bus0.out_carry_o), 32'd0);

    for (int i = 0; i < 7; i++) begin
      send(tbl[i].s, tbl[i].c, tbl[i].r, tbl[i].co);
      collect($sformatf("vec%0d", i));
    end

    repeat (3) @(negedge clk);
    check_eq("idle retains result", 32'(bus0.out_result_o), 32'hFFFF);

    // Backpressure: second pair is offered throughout HOLD and must wait for IDLE.
    send(16'h1111, 16'h2222, 16'h3333, 1'b0);
    wait_valid(lat);
    check_eq("bp first latency", 32'(lat), 32'd4);
    bus0.in_valid_i = 1'b1;
    bus0.in_sum_i   = 16'h0F0F;
    bus0.in_carry_i = 16'h0101;
    e.r = 16'h1010;
    e.co = 1'b0;
    sb_q.push_back(e);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("bp hold out_valid", 32'(bus0.out_valid_o), 32'd1);
      check_eq("bp hold in_ready", 32'(bus0.in_ready_o), 32'd0);
      check_eq("bp hold result", 32'(bus0.out_result_o), 32'h3333);
    end
    pop_compare("bp first");
    bus0.out_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus0.out_ready_i = 1'b0;
    check_eq("bp back to idle", 32'(bus0.in_ready_o), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus0.in_valid_i = 1'b0;
    collect("bp second");

    // Reset after two chunks of a pair: the pair is dropped.
    bus0.in_valid_i = 1'b1;
    bus0.in_sum_i   = 16'h00FF;
    bus0.in_carry_i = 16'h0001;
    @(posedge clk);
    @(negedge clk);
    bus0.in_valid_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst in_ready", 32'(bus0.in_ready_o), 32'd1);
    check_eq("midrst out_valid", 32'(bus0.out_valid_o), 32'd0);
    check_eq("midrst result", 32'(bus0.out_result_o), 32'h0);
    check_eq("midrst carry", 32'(bus0.out_carry_o), 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus0.out_valid_o === 1'b1) seen++;
    end
    check_eq("midrst no output", 32'(seen), 32'd0);
    send(16'h00FF, 16'h0001, 16'h0100, 1'b0);
    collect("after midrst");

    // Reset wins over a handshake on the same edge.
    rst = 1'b1;
    bus0.in_valid_i = 1'b1;
    bus0.in_sum_i   = 16'h1234;
    bus0.in_carry_i = 16'h0001;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus0.in_valid_i = 1'b0;
    check_eq("rst dominates in_ready", 32'(bus0.in_ready_o), 32'd1);
    check_eq("rst dominates result", 32'(bus0.out_result_o), 32'h0);

    for (int i = 0; i < 1000; i++) begin
      s = 16'($urandom);
      c = 16'($urandom);
      full = {1'b0, s} + {1'b0, c};
      e.r = full[W-1:0];
      e.co = full[W];
      q16.push_back(e);
      q1.push_back(e);
      bus16.in_valid_i = 1'b1; bus16.in_sum_i = s; bus16.in_carry_i = c;
      bus1.in_valid_i = 1'b1;  bus1.in_sum_i = s;  bus1.in_carry_i = c;
      @(posedge clk);
      @(negedge clk);
      bus16.in_valid_i = 1'b0; bus16.in_sum_i = 16'($urandom);
      bus1.in_valid_i = 1'b0;  bus1.in_carry_i = 16'($urandom);
      d16 = 1'b0;
      d1 = 1'b0;
      lat = 0;
      while (!(d16 && d1) && lat < 64) begin
        @(posedge clk);
        @(negedge clk);
        lat++;
        if (!d16 && bus16.out_valid_o === 1'b1) begin
          d16 = 1'b1;
          check_eq("cw16 latency", 32'(lat), 32'd1);
          cmp_exp("cw16", q16.pop_front(), bus16.out_result_o, bus16.out_carry_o);
        end
        if (!d1 && bus1.out_valid_o === 1'b1) begin
          d1 = 1'b1;
          check_eq("cw1 latency", 32'(lat), 32'd16);
          cmp_exp("cw1", q1.pop_front(), bus1.out_result_o, bus1.out_carry_o);
        end
      end
      if (!(d16 && d1)) begin
        n_checks++;
        n_fail++;
        $display("FAIL sweep timeout: pair %0d done16=%0d done1=%0d", i, d16, d1);
        break;
      end
      @(posedge clk);
      @(negedge clk);
    end

    check_eq("scoreboards drained", 32'(sb_q.size() + q16.size() + q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/csa_resolver.md
# csa_resolver

Sequential carry-propagate resolver that closes a carry-save reduction tree. It accepts one redundant operand pair (sum vector, carry vector) as produced by a column array of (m,2)-compressors. It adds the pair chunk by chunk over several cycles and returns the binary result and a carry-out. It sits behind multi-operand carry-save adders and trades latency for a short ChunkWidth-bit carry chain.

## Interface
- Width, default 16: operand/result width in bits; must be ≥ 2.
- ChunkWidth, default 4: bits resolved per cycle; must divide Width; NumChunks = Width/ChunkWidth.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- in_valid_i  in  1  operand pair valid.
- in_ready_o  out  1  resolver can accept a pair.
- in_sum_i  in  Width  sum vector.
- in_carry_i  in  Width  carry vector, already aligned to bit weight (caller performs the left shift of compressor carries).
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts result.
- out_result_o  out  Width  (in_sum_i + in_carry_i) mod 2^Width.
- out_carry_o  out  1  bit Width of the full sum (overflow).

## Operation
- States: IDLE, ADD, HOLD. Reset state is IDLE.
- IDLE:
  - in_ready_o = 1.
  - On in_valid_i && in_ready_o: latch in_sum_i and in_carry_i into operand registers, clear the chunk index and carry register, go to ADD.
- ADD:
  - in_ready_o = 0.
  - Each cycle, chunk k (bits k·ChunkWidth+ChunkWidth-1 : k·ChunkWidth) = sum_chunk + carry_chunk + carry register.
  - The low ChunkWidth bits are written to result chunk k; the chunk carry-out becomes the new carry register; k increments.
  - After chunk NumChunks-1: out_carry_o takes the final carry and the state goes to HOLD.
- HOLD:
  - out_valid_o = 1; in_ready_o = 0.
  - On out_ready_i, go to IDLE.
- in_valid_i outside IDLE is ignored. Input pins are not sampled after acceptance.
- Unsigned modular arithmetic, no saturation. Signed use is valid: discard out_carry_o.
- out_result_o and out_carry_o are registers that change only in ADD. They retain the last result through IDLE.
- in_ready_o and out_valid_o are decoded from the state register only, with no combinational path from inputs.
- Reset at any clock edge with rst_i = 1:
  - next state is IDLE;
  - out_valid_o = 0, out_result_o = 0, out_carry_o = 0;
  - chunk index and carry register are cleared.
  - An operation in flight is dropped with no output.
- Reset dominates a simultaneous input handshake.

## Timing
- Handshake: a transfer occurs on the edge where valid && ready.
- Latency: pair accepted at edge t → out_valid_o high after edge t+NumChunks (4 cycles at defaults).
- out_valid_o stays high, with result stable, until the edge where out_ready_i = 1. in_ready_o rises on the following cycle.
- Throughput: one pair per NumChunks + 2 cycles with out_ready_i tied high.
- ChunkWidth = Width: ADD lasts exactly one cycle and latency is 1.
- Critical path: one ChunkWidth-bit adder plus carry register. There is no Width-bit ripple.

## Test plan
- Reset: hold rst_i for 2 cycles → in_ready_o = 1, out_valid_o = 0, out_result_o = 0x0000, out_carry_o = 0.
- Basic add (defaults): sum = 0x1234, carry = 0x0001, accepted at edge t → out_valid_o at t+4, result 0x1235, out_carry_o = 0.
- Full ripple across all chunks: sum = 0xFFFF, carry = 0x0001 → result 0x0000, out_carry_o = 1.
- Maximum values: sum = 0xFFFF, carry = 0xFFFF → result 0xFFFE, out_carry_o = 1.
- Backpressure: out_ready_i = 0 for 5 cycles during HOLD with in_valid_i = 1 and a new pair → result stays stable, in_ready_o = 0, new pair not taken. Then out_ready_i = 1 → IDLE, then accept; second result correct.
- Reset mid-ADD: assert rst_i after 2 chunks of sum = 0x00FF, carry = 0x0001 → next cycle IDLE, out_valid_o never asserted, outputs 0. A subsequent pair resolves correctly.
- Parameter sweep:
  - ChunkWidth = 16 → latency 1.
  - ChunkWidth = 1 → latency 16.
  - Each with 1000 random pairs against a reference sum.
